// File: rtl/kd_tree_pkg.sv
// Shared types and default widths for the kd-tree sequencer slice.
//   kd_seq_state_t      : sequencer state encoding
//   DEF_INTERNAL_WIDTH  : aggregated node word width (index + median)
//   DEF_PATCH_WIDTH     : query patch width
//   DEF_ADDRESS_WIDTH   : node address / leaf index width
package kd_tree_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_DRAIN  = 2'd3
    } kd_seq_state_t;

    localparam int DEF_INTERNAL_WIDTH = 22;
    localparam int DEF_PATCH_WIDTH    = 55;
    localparam int DEF_ADDRESS_WIDTH  = 8;

endpackage

// File: rtl/kd_seq_result_fifo.sv
// Result FIFO for the kd-tree sequencer: synchronous, registered outputs.
// A push into an empty FIFO appears on the outputs the following cycle.
// Ports:
//   clk, rst            : clock, async active-high reset
//   push, push_data     : write strobe and word (never pushed when full)
//   pop_ready           : consumer accepts out_data when out_valid
//   out_valid, out_data : registered head of queue
//   empty               : nothing stored and nothing presented
module kd_seq_result_fifo
    import kd_tree_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             take;
    logic             from_mem;
    logic             bypass;
    logic             store;

    // Output register reloads when empty or being popped; stored words are
    // older than the incoming push, so they take priority over the bypass.
    assign take     = !out_valid || pop_ready;
    assign from_mem = take && (cnt != '0);
    assign bypass   = take && (cnt == '0) && push;
    assign store    = push && !bypass;
    assign empty    = !out_valid && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (take) begin
                if (from_mem) begin
                    out_data <= mem[rd_ptr];
                end else if (bypass) begin
                    out_data <= push_data;
                end
                out_valid <= from_mem || bypass;
            end
            if (store)    wr_ptr <= wr_ptr + 1'b1;
            if (from_mem) rd_ptr <= rd_ptr + 1'b1;
            case ({store, from_mem})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/kd_tree_sequencer.sv
// kd-tree sequencer: loads NUM_NODES internal-node words into the tree, then
// streams query patches with credit-based flow control and returns
// {qid, leaf} results in issue order.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   start, query_count               : run request (IDLE only)
//   node_valid/ready/data            : aggregator node stream
//   tree_fsm_enable                  : high in LOAD and SEARCH
//   tree_sender_enable/data, tree_node_addr : node write to tree
//   patch_valid/ready/data           : query stream
//   tree_patch_valid, tree_patch_out : patch issue to tree
//   tree_leaf_index                  : tree result, TREE_LATENCY after issue
//   result_valid/ready/leaf/qid      : result stream
//   busy, done                       : run status, end-of-run pulse
// Optional macro KD_SEQ_PERF_CNT_EN adds perf_load_cycles and
// perf_stall_cycles (saturating, cleared on start).
module kd_tree_sequencer
    import kd_tree_pkg::*;
#(
    parameter int INTERNAL_WIDTH = DEF_INTERNAL_WIDTH,
    parameter int PATCH_WIDTH    = DEF_PATCH_WIDTH,
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int NUM_NODES      = 255,
    parameter int TREE_LATENCY   = 8,
    parameter int OUT_DEPTH      = 16,
    parameter int QID_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [QID_WIDTH-1:0]      query_count,
    input  logic                      node_valid,
    output logic                      node_ready,
    input  logic [INTERNAL_WIDTH-1:0] node_data,
    output logic                      tree_fsm_enable,
    output logic                      tree_sender_enable,
    output logic [INTERNAL_WIDTH-1:0] tree_sender_data,
    output logic [ADDRESS_WIDTH-1:0]  tree_node_addr,
    input  logic                      patch_valid,
    output logic                      patch_ready,
    input  logic [PATCH_WIDTH-1:0]    patch_data,
    output logic                      tree_patch_valid,
    output logic [PATCH_WIDTH-1:0]    tree_patch_out,
    input  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [ADDRESS_WIDTH-1:0]  result_leaf,
    output logic [QID_WIDTH-1:0]      result_qid,
    output logic                      busy,
    output logic                      done
`ifdef KD_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               perf_load_cycles,
    output logic [31:0]               perf_stall_cycles
`endif
);

    localparam int LW = ADDRESS_WIDTH + 1;
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    kd_seq_state_t state, state_next;

    logic [LW-1:0]        load_cnt;
    logic [QID_WIDTH-1:0] q_count;
    logic [QID_WIDTH-1:0] issued;
    logic [QID_WIDTH-1:0] qid_reg;
    logic [CW-1:0]        credits;
    logic [TREE_LATENCY-1:0] pipe_v;
    logic [QID_WIDTH-1:0] pipe_q [TREE_LATENCY];
    logic                 node_hs;
    logic                 issue;
    logic                 pop;
    logic                 fifo_empty;
    logic                 pipe_empty;
    logic [QID_WIDTH+ADDRESS_WIDTH-1:0] fifo_out;

    assign node_ready      = (state == ST_LOAD);
    assign patch_ready     = (state == ST_SEARCH) && (credits != '0) && (issued < q_count);
    assign node_hs         = node_valid && node_ready;
    assign issue           = patch_valid && patch_ready;
    assign pop             = result_valid && result_ready;
    assign tree_fsm_enable = (state == ST_LOAD) || (state == ST_SEARCH);
    assign busy            = (state != ST_IDLE);
    assign pipe_empty      = !tree_patch_valid && (pipe_v == '0) && fifo_empty;
    assign result_qid      = fifo_out[QID_WIDTH+ADDRESS_WIDTH-1:ADDRESS_WIDTH];
    assign result_leaf     = fifo_out[ADDRESS_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            ST_LOAD:   if (node_hs && load_cnt == LW'(NUM_NODES - 1))
                           state_next = (q_count == '0) ? ST_DRAIN : ST_SEARCH;
            ST_SEARCH: if (issue && issued == q_count - 1'b1) state_next = ST_DRAIN;
            ST_DRAIN:  if (pipe_empty) begin
                           done       = 1'b1;
                           state_next = ST_IDLE;
                       end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt           <= '0;
            q_count            <= '0;
            issued             <= '0;
            qid_reg            <= '0;
            credits            <= CW'(OUT_DEPTH);
            tree_sender_enable <= 1'b0;
            tree_sender_data   <= '0;
            tree_node_addr     <= '0;
            tree_patch_valid   <= 1'b0;
            tree_patch_out     <= '0;
            pipe_v             <= '0;
            for (int i = 0; i < TREE_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                q_count  <= query_count;
                load_cnt <= '0;
                issued   <= '0;
            end
            tree_sender_enable <= node_hs;
            if (node_hs) begin
                tree_sender_data <= node_data;
                tree_node_addr   <= load_cnt[ADDRESS_WIDTH-1:0];
                load_cnt         <= load_cnt + 1'b1;
            end
            tree_patch_valid <= issue;
            if (issue) begin
                tree_patch_out <= patch_data;
                qid_reg        <= issued;
                issued         <= issued + 1'b1;
            end
            // The issue register is stage 0; the last pipe stage lines up
            // with the cycle the tree presents the matching leaf index.
            pipe_v[0] <= tree_patch_valid;
            pipe_q[0] <= qid_reg;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
            // Credits cover in-flight plus buffered results, so the FIFO
            // can never overflow.
            case ({issue, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    kd_seq_result_fifo #(
        .WIDTH (QID_WIDTH + ADDRESS_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_v[TREE_LATENCY-1]),
        .push_data ({pipe_q[TREE_LATENCY-1], tree_leaf_index}),
        .pop_ready (result_ready),
        .out_valid (result_valid),
        .out_data  (fifo_out),
        .empty     (fifo_empty)
    );

`ifdef KD_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (state == ST_IDLE && start) begin
            perf_load_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state == ST_LOAD && perf_load_cycles != '1)
                perf_load_cycles <= perf_load_cycles + 32'd1;
            if (state == ST_SEARCH && patch_valid && !patch_ready && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
